// File: rtl/split_issue_pkg.sv
// Shared constants, FSM state type and width helpers for the split/issue front-end.
// Modules derive their own widths from their parameters; defaults here match the base config.
package split_issue_pkg;

   localparam int unsigned DEF_LINE_BYTES = 16;
   localparam int unsigned DEF_NBANKS     = 2;
   localparam int unsigned DEF_ADDR_W     = 15;
   localparam int unsigned DEF_ID_W       = 7;

   localparam int unsigned OFF_W  = $clog2(DEF_LINE_BYTES);
   localparam int unsigned LINE_W = DEF_ADDR_W - OFF_W;
   localparam int unsigned BANK_W = (DEF_NBANKS > 1) ? $clog2(DEF_NBANKS) : 1;

   localparam logic PART_LO = 1'b0;
   localparam logic PART_HI = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   function automatic int unsigned bank_w_f(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/split_line_issue_rotate.sv
// Combinational line alignment: rotates write data into line position and builds the
// low/high byte masks plus the line-crossing flag for one request.
module line_rotate_mask
   import split_issue_pkg::*;
#(
   parameter int unsigned  LINE_BYTES = DEF_LINE_BYTES,
   localparam int unsigned OW         = $clog2(LINE_BYTES),
   localparam int unsigned DW         = LINE_BYTES * 8
) (
   input  logic [OW-1:0]         i_off,
   input  logic [OW-1:0]         i_size,
   input  logic [DW-1:0]         i_data,
   output logic [DW-1:0]         o_rot,
   output logic [LINE_BYTES-1:0] o_mask_lo,
   output logic [LINE_BYTES-1:0] o_mask_hi,
   output logic                  o_cross
);

   // Last byte index of the request, one bit wider so it may run past the line.
   logic [OW:0] w_end;

   assign w_end   = {1'b0, i_off} + {1'b0, i_size};
   assign o_cross = (w_end >= (OW+1)'(LINE_BYTES));

   always_comb begin
      logic [OW-1:0] v_src;
      v_src     = '0;
      o_rot     = '0;
      o_mask_lo = '0;
      o_mask_hi = '0;
      for (int j = 0; j < int'(LINE_BYTES); j++) begin
         v_src             = OW'(j) - i_off;
         o_rot[j*8 +: 8]   = i_data[{v_src, 3'b000} +: 8];
         o_mask_lo[j]      = ((OW+1)'(j) >= {1'b0, i_off}) && ((OW+1)'(j) <= w_end);
         o_mask_hi[j]      = ((OW+1)'(j + int'(LINE_BYTES)) <= w_end);
      end
   end

endmodule

// File: rtl/split_line_issue.sv
// Cache front-end issue stage: splits line-crossing requests into low/high parts and
// presents each part on its line-interleaved bank until that bank accepts it.
module split_line_issue
   import split_issue_pkg::*;
#(
   parameter int unsigned  LINE_BYTES = DEF_LINE_BYTES,
   parameter int unsigned  NBANKS     = DEF_NBANKS,
   parameter int unsigned  ADDR_W     = DEF_ADDR_W,
   parameter int unsigned  ID_W       = DEF_ID_W,
   localparam int unsigned OW         = $clog2(LINE_BYTES),
   localparam int unsigned LW         = ADDR_W - OW,
   localparam int unsigned BW         = bank_w_f(NBANKS),
   localparam int unsigned DW         = LINE_BYTES * 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic [ADDR_W-1:0]            i_req_addr,
   input  logic [OW-1:0]                i_req_size,
   input  logic                         i_req_w,
   input  logic [DW-1:0]                i_req_wdata,
   input  logic [ID_W-1:0]              i_req_id,
   output logic [NBANKS-1:0]            o_bank_valid,
   input  logic [NBANKS-1:0]            i_bank_ready,
   output logic [NBANKS*LW-1:0]         o_bank_line,
   output logic [NBANKS*LINE_BYTES-1:0] o_bank_mask,
   output logic [NBANKS*DW-1:0]         o_bank_wdata,
   output logic [NBANKS-1:0]            o_bank_w,
   output logic [NBANKS*ID_W-1:0]       o_bank_id,
   output logic [NBANKS-1:0]            o_bank_part,
   output logic [NBANKS-1:0]            o_bank_split,
   output logic                         o_busy
);

   state_e                r_state;
   logic                  r_pend_lo;
   logic                  r_pend_hi;
   logic [LW-1:0]         r_line_lo;
   logic [DW-1:0]         r_rot;
   logic [LINE_BYTES-1:0] r_mask_lo;
   logic [LINE_BYTES-1:0] r_mask_hi;
   logic                  r_w;
   logic [ID_W-1:0]       r_id;
   logic                  r_split;

   logic [DW-1:0]         w_rot;
   logic [LINE_BYTES-1:0] w_mask_lo;
   logic [LINE_BYTES-1:0] w_mask_hi;
   logic                  w_cross;
   logic [LW-1:0]         w_line_hi;
   logic [BW-1:0]         w_bank_lo;
   logic [BW-1:0]         w_bank_hi;
   logic [NBANKS-1:0]     w_sel_lo;
   logic [NBANKS-1:0]     w_sel_hi;
   logic                  w_pend_lo_d;
   logic                  w_pend_hi_d;

   line_rotate_mask #(
      .LINE_BYTES (LINE_BYTES)
   ) u_rotate (
      .i_off     (i_req_addr[OW-1:0]),
      .i_size    (i_req_size),
      .i_data    (i_req_wdata),
      .o_rot     (w_rot),
      .o_mask_lo (w_mask_lo),
      .o_mask_hi (w_mask_hi),
      .o_cross   (w_cross)
   );

   // Line + 1 wraps naturally at the top of the address space.
   assign w_line_hi = r_line_lo + LW'(1);
   assign w_bank_lo = BW'(r_line_lo & LW'(NBANKS - 1));
   assign w_bank_hi = BW'(w_line_hi & LW'(NBANKS - 1));

   // With a single bank both parts share it, so the high part waits for the low part.
   always_comb begin
      w_sel_lo = '0;
      w_sel_hi = '0;
      for (int b = 0; b < int'(NBANKS); b++) begin
         w_sel_lo[b] = r_pend_lo && (w_bank_lo == BW'(b));
         w_sel_hi[b] = r_pend_hi && (w_bank_hi == BW'(b)) && ((NBANKS > 1) || !r_pend_lo);
      end
   end

   assign w_pend_lo_d = r_pend_lo && !(|(w_sel_lo & i_bank_ready));
   assign w_pend_hi_d = r_pend_hi && !(|(w_sel_hi & i_bank_ready));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_pend_lo <= 1'b0;
         r_pend_hi <= 1'b0;
         r_line_lo <= '0;
         r_rot     <= '0;
         r_mask_lo <= '0;
         r_mask_hi <= '0;
         r_w       <= 1'b0;
         r_id      <= '0;
         r_split   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_line_lo <= i_req_addr[ADDR_W-1:OW];
                  r_rot     <= w_rot;
                  r_mask_lo <= w_mask_lo;
                  r_mask_hi <= w_mask_hi;
                  r_w       <= i_req_w;
                  r_id      <= i_req_id;
                  r_split   <= w_cross;
                  r_pend_lo <= 1'b1;
                  r_pend_hi <= w_cross;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_pend_lo <= w_pend_lo_d;
               r_pend_hi <= w_pend_hi_d;
               if (!w_pend_lo_d && !w_pend_hi_d) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready = (r_state == IDLE);
   assign o_busy      = (r_state == ISSUE);

   always_comb begin
      o_bank_valid = '0;
      o_bank_line  = '0;
      o_bank_mask  = '0;
      o_bank_wdata = '0;
      o_bank_w     = '0;
      o_bank_id    = '0;
      o_bank_part  = '0;
      o_bank_split = '0;
      for (int b = 0; b < int'(NBANKS); b++) begin
         if (w_sel_lo[b]) begin
            o_bank_line[b*LW +: LW]                 = r_line_lo;
            o_bank_mask[b*LINE_BYTES +: LINE_BYTES] = r_mask_lo;
            o_bank_part[b]                          = PART_LO;
         end else if (w_sel_hi[b]) begin
            o_bank_line[b*LW +: LW]                 = w_line_hi;
            o_bank_mask[b*LINE_BYTES +: LINE_BYTES] = r_mask_hi;
            o_bank_part[b]                          = PART_HI;
         end
         if (w_sel_lo[b] || w_sel_hi[b]) begin
            o_bank_valid[b]           = 1'b1;
            o_bank_wdata[b*DW +: DW]  = r_rot;
            o_bank_w[b]               = r_w;
            o_bank_id[b*ID_W +: ID_W] = r_id;
            o_bank_split[b]           = r_split;
         end
      end
   end

endmodule

// File: tb/tb_split_line_issue.sv
// Scoreboard bench: expected bank transfers are queued per bank when a request is issued;
// a negedge monitor pops and compares on every bank handshake.
module tb_split_line_issue;

   typedef struct packed {
      logic [10:0]  line;
      logic [15:0]  mask;
      logic [127:0] data;
      logic         w;
      logic [6:0]   id;
      logic         part;
      logic         split;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid, s_req_valid;
   logic         req_ready, s_req_ready;
   logic [14:0]  req_addr;
   logic [3:0]   req_size;
   logic         req_w;
   logic [127:0] req_wdata;
   logic [6:0]   req_id;

   logic [1:0]   b_valid, b_ready, b_w, b_part, b_split;
   logic [21:0]  b_line;
   logic [31:0]  b_mask;
   logic [255:0] b_wdata;
   logic [13:0]  b_id;
   logic         busy;

   logic         s_valid, s_ready, s_w, s_part, s_split, s_busy;
   logic [10:0]  s_line;
   logic [15:0]  s_mask;
   logic [127:0] s_wdata;
   logic [6:0]   s_id;

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t qs[$];
   logic [1:0] hold2 = 2'b00;
   exp_t held2[2];

   always #5 clk = ~clk;

   split_line_issue #(.LINE_BYTES(16), .NBANKS(2), .ADDR_W(15), .ID_W(7)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req_addr), .i_req_size(req_size), .i_req_w(req_w), .i_req_wdata(req_wdata),
      .i_req_id(req_id), .o_bank_valid(b_valid), .i_bank_ready(b_ready), .o_bank_line(b_line),
      .o_bank_mask(b_mask), .o_bank_wdata(b_wdata), .o_bank_w(b_w), .o_bank_id(b_id),
      .o_bank_part(b_part), .o_bank_split(b_split), .o_busy(busy)
   );

   split_line_issue #(.LINE_BYTES(16), .NBANKS(1), .ADDR_W(15), .ID_W(7)) u_dut1 (
      .i_clk(clk), .i_reset(reset), .i_req_valid(s_req_valid), .o_req_ready(s_req_ready),
      .i_req_addr(req_addr), .i_req_size(req_size), .i_req_w(req_w), .i_req_wdata(req_wdata),
      .i_req_id(req_id), .o_bank_valid(s_valid), .i_bank_ready(s_ready), .o_bank_line(s_line),
      .o_bank_mask(s_mask), .o_bank_wdata(s_wdata), .o_bank_w(s_w), .o_bank_id(s_id),
      .o_bank_part(s_part), .o_bank_split(s_split), .o_busy(s_busy)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [10:0] line, input logic [15:0] mask,
                               input logic [127:0] data, input logic w, input logic [6:0] id,
                               input logic part, input logic split);
      exp_t e;
      e.line = line; e.mask = mask; e.data = data; e.w = w;
      e.id = id; e.part = part; e.split = split;
      return e;
   endfunction

   function automatic exp_t cur2(input int b);
      exp_t e;
      e.line = b_line[b*11 +: 11]; e.mask = b_mask[b*16 +: 16];
      e.data = b_wdata[b*128 +: 128]; e.w = b_w[b]; e.id = b_id[b*7 +: 7];
      e.part = b_part[b]; e.split = b_split[b];
      return e;
   endfunction

   task automatic unexpected(input string name, input exp_t cur);
      n_total++;
      n_bad++;
      $display("FAIL %s: got transfer %h want none", name, cur);
   endtask

   // Monitor: compare every bank handshake against its queue; held parts must not change.
   always @(negedge clk) begin
      exp_t cur;
      exp_t e;
      for (int b = 0; b < 2; b++) begin
         cur = cur2(b);
         if (hold2[b]) chk($sformatf("bank%0d_stable", b), 256'(cur), 256'(held2[b]));
         if (b_valid[b] && b_ready[b]) begin
            if (b == 0) begin
               if (q0.size() == 0) unexpected("bank0_xfer", cur);
               else begin e = q0.pop_front(); chk("bank0_xfer", 256'(cur), 256'(e)); end
            end else begin
               if (q1.size() == 0) unexpected("bank1_xfer", cur);
               else begin e = q1.pop_front(); chk("bank1_xfer", 256'(cur), 256'(e)); end
            end
         end
         hold2[b] = b_valid[b] && !b_ready[b] && !reset;
         held2[b] = cur;
      end
      if (s_valid && s_ready) begin
         cur = mk(s_line, s_mask, s_wdata, s_w, s_id, s_part, s_split);
         if (qs.size() == 0) unexpected("single_xfer", cur);
         else begin e = qs.pop_front(); chk("single_xfer", 256'(cur), 256'(e)); end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request to dut (0 = two-bank, 1 = single-bank); returns just after acceptance.
   task automatic send(input int which, input logic [14:0] a, input logic [3:0] sz,
                       input logic w, input logic [127:0] d, input logic [6:0] id);
      int k;
      k = 0;
      while (!((which == 0) ? req_ready : s_req_ready) && k < 20) begin
         step();
         k++;
      end
      if (k == 20) begin
         n_total++;
         n_bad++;
         $display("FAIL send_timeout: got req_ready 0 want 1 within 20 cycles");
      end
      req_addr = a; req_size = sz; req_w = w; req_wdata = d; req_id = id;
      if (which == 0) req_valid = 1'b1;
      else s_req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      s_req_valid = 1'b0;
   endtask

   localparam logic [127:0] D1 = 128'hDDCCBBAA;
   localparam logic [127:0] R1 = 128'hDDCCBBAA_00000000;
   localparam logic [127:0] D2 = 128'h44332211;
   localparam logic [127:0] R2 = 128'h2211_0000_0000_0000_0000_0000_0000_4433;
   localparam logic [127:0] D4 = 128'h08070605_04030201;
   localparam logic [127:0] R4 = 128'h04030201_00000000_00000000_08070605;
   localparam logic [127:0] D5 = 128'hBEEF;
   localparam logic [127:0] R5 = 128'hEF00_0000_0000_0000_0000_0000_0000_00BE;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; s_req_valid = 1'b0;
      req_addr = '0; req_size = '0; req_w = 1'b0; req_wdata = '0; req_id = '0;
      b_ready = 2'b00; s_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 256'(req_ready), 256'(1'b1));
      chk("rst_busy", 256'(busy), 256'(1'b0));
      chk("rst_valid", 256'(b_valid), 256'(2'b00));
      chk("rst_single_ready", 256'(s_req_ready), 256'(1'b1));
      step();

      // 1: single-line write
      b_ready = 2'b11;
      q0.push_back(mk(11'h010, 16'h00F0, R1, 1'b1, 7'h11, 1'b0, 1'b0));
      send(0, 15'h0104, 4'd3, 1'b1, D1, 7'h11);
      @(negedge clk);
      chk("t1_valid", 256'(b_valid), 256'(2'b01));
      chk("t1_busy", 256'(busy), 256'(1'b1));
      chk("t1_req_ready", 256'(req_ready), 256'(1'b0));
      @(negedge clk);
      chk("t1_idle_valid", 256'(b_valid), 256'(2'b00));
      chk("t1_idle_ready", 256'(req_ready), 256'(1'b1));
      step();

      // 2: crossing request, both banks accept at once
      q0.push_back(mk(11'h010, 16'hC000, R2, 1'b1, 7'h22, 1'b0, 1'b1));
      q1.push_back(mk(11'h011, 16'h0003, R2, 1'b1, 7'h22, 1'b1, 1'b1));
      send(0, 15'h010E, 4'd3, 1'b1, D2, 7'h22);
      @(negedge clk);
      chk("t2_valid", 256'(b_valid), 256'(2'b11));
      @(negedge clk);
      chk("t2_done", 256'(req_ready), 256'(1'b1));
      step();

      // 3: bank1 stalls three cycles
      b_ready = 2'b01;
      q0.push_back(mk(11'h010, 16'hC000, R2, 1'b0, 7'h33, 1'b0, 1'b1));
      q1.push_back(mk(11'h011, 16'h0003, R2, 1'b0, 7'h33, 1'b1, 1'b1));
      send(0, 15'h010E, 4'd3, 1'b0, D2, 7'h33);
      @(negedge clk);
      chk("t3_valid0", 256'(b_valid), 256'(2'b11));
      step();
      @(negedge clk);
      chk("t3_valid1", 256'(b_valid), 256'(2'b10));
      chk("t3_ready1", 256'(req_ready), 256'(1'b0));
      step();
      @(negedge clk);
      chk("t3_valid2", 256'(b_valid), 256'(2'b10));
      step();
      b_ready = 2'b11;
      @(negedge clk);
      chk("t3_ready3", 256'(req_ready), 256'(1'b0));
      @(negedge clk);
      chk("t3_ready4", 256'(req_ready), 256'(1'b1));
      chk("t3_busy4", 256'(busy), 256'(1'b0));
      step();

      // 4: top line wraps to line 0
      q1.push_back(mk(11'h7FF, 16'hF000, R4, 1'b1, 7'h44, 1'b0, 1'b1));
      q0.push_back(mk(11'h000, 16'h000F, R4, 1'b1, 7'h44, 1'b1, 1'b1));
      send(0, 15'h7FFC, 4'd7, 1'b1, D4, 7'h44);
      @(negedge clk);
      chk("t4_valid", 256'(b_valid), 256'(2'b11));
      step();

      // 5: single bank serialises low then high
      s_ready = 1'b1;
      qs.push_back(mk(11'h001, 16'h8000, R5, 1'b1, 7'h55, 1'b0, 1'b1));
      qs.push_back(mk(11'h002, 16'h0001, R5, 1'b1, 7'h55, 1'b1, 1'b1));
      send(1, 15'h001F, 4'd1, 1'b1, D5, 7'h55);
      @(negedge clk);
      chk("t5_lo_valid", 256'(s_valid), 256'(1'b1));
      chk("t5_lo_part", 256'(s_part), 256'(1'b0));
      step();
      @(negedge clk);
      chk("t5_hi_valid", 256'(s_valid), 256'(1'b1));
      chk("t5_hi_part", 256'(s_part), 256'(1'b1));
      step();
      @(negedge clk);
      chk("t5_busy", 256'(s_busy), 256'(1'b0));
      step();

      // 6: reset mid-ISSUE drops the held part
      b_ready = 2'b00;
      send(0, 15'h0104, 4'd3, 1'b1, D1, 7'h66);
      @(negedge clk);
      chk("t6_held", 256'(b_valid), 256'(2'b01));
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_valid", 256'(b_valid), 256'(2'b00));
      chk("t6_busy", 256'(busy), 256'(1'b0));
      chk("t6_req_ready", 256'(req_ready), 256'(1'b1));
      step();
      // valid during reset must not be taken
      reset = 1'b1;
      req_valid = 1'b1;
      step();
      reset = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid_busy", 256'(busy), 256'(1'b0));
      step();
      b_ready = 2'b11;
      q0.push_back(mk(11'h010, 16'h00F0, R1, 1'b1, 7'h67, 1'b0, 1'b0));
      send(0, 15'h0104, 4'd3, 1'b1, D1, 7'h67);
      @(negedge clk);
      chk("t6_after_valid", 256'(b_valid), 256'(2'b01));
      step();

      repeat (3) step();
      chk("q0_drained", 256'(q0.size()), 256'(0));
      chk("q1_drained", 256'(q1.size()), 256'(0));
      chk("qs_drained", 256'(qs.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/split_line_issue.md
Name: split_line_issue

Overview:
- Parametrised successor to the cache front-end align/swap stage.
- Accepts one memory request (physical address, byte count, write data, ID) over a valid/ready handshake.
- Splits a request that crosses a cache-line boundary into low and high line parts, rotates data into line position and generates byte masks.
- Issues each part to one of NBANKS line-interleaved bank ports with independent per-bank handshakes, holding the request until every part is accepted. Sits between the TLB/address stage and the cache banks.

Parameters:
- LINE_BYTES, 16, bytes per cache line; power of 2, at least 4.
- NBANKS, 2, number of line-interleaved banks; power of 2, at least 1.
- ADDR_W, 15, physical address width.
- ID_W, 7, request tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  physical byte address
- req_size  in  $clog2(LINE_BYTES)  byte count minus 1
- req_w  in  1  1 = write, 0 = read
- req_wdata  in  LINE_BYTES*8  write data, byte 0 at bits [7:0]
- req_id  in  ID_W  request tag
- bank_valid  out  NBANKS  per-bank part valid
- bank_ready  in  NBANKS  per-bank accept
- bank_line  out  NBANKS*(ADDR_W-$clog2(LINE_BYTES))  line address per bank
- bank_mask  out  NBANKS*LINE_BYTES  byte-enable per bank
- bank_wdata  out  NBANKS*LINE_BYTES*8  line-aligned data per bank
- bank_w  out  NBANKS  write flag per bank
- bank_id  out  NBANKS*ID_W  tag per bank
- bank_part  out  NBANKS  0 = low part, 1 = high part
- bank_split  out  NBANKS  1 = request has two parts
- busy  out  1  a request is held

Behaviour:
- Derived fields: off = req_addr[$clog2(LINE_BYTES)-1:0]; line = the upper address bits; bank = line mod NBANKS.
- Crossing request: off + req_size >= LINE_BYTES. The high part uses line+1 modulo 2^(ADDR_W-$clog2(LINE_BYTES)), so the top line wraps to line 0.
- Data path: rotated = req_wdata circularly rotated left by off*8 bits. Both parts carry the same rotated data.
- Masks:
  - Low mask: bytes j with off <= j <= min(off+req_size, LINE_BYTES-1).
  - High mask: bytes j < off+req_size+1-LINE_BYTES; zero if the request does not cross.
- States: IDLE and ISSUE.
  - req_ready = 1 only in IDLE.
  - A handshake in IDLE registers all derived fields, sets pend_lo = 1 and pend_hi = crossing, and moves to ISSUE.
- ISSUE timing: bank_valid asserts the cycle after acceptance.
  - Part P is presented on bank(P) while pend_P = 1.
  - bank_valid & bank_ready clears pend_P at the clock edge.
  - bank_valid for that bank drops the next cycle.
- Completion: when no pend bits remain after an edge, the state returns to IDLE. Throughput is at most one request per 2 cycles; a crossing request with both parts accepted in the first ISSUE cycle also takes 2 cycles.
- Stability: while pend_P = 1, the bank outputs for part P stay stable regardless of bank_ready.
- Same-bank case (NBANKS = 1 only): parts are serialised. Low is presented first; high is presented the cycle after low is accepted.
- Bank separation (NBANKS >= 2): adjacent lines map to different banks, so both parts may present in the same cycle and are accepted independently in any order.
- Idle outputs: outputs of banks with no pending part are zero.
- busy = (state == ISSUE).
- Reset (synchronous, also mid-ISSUE):
  - state = IDLE, pend bits cleared, all bank_* outputs = 0, busy = 0, req_ready = 1 from the cycle after reset.
  - Dropped parts are not replayed.
- Inputs while req_ready = 0 are ignored. req_valid & req_ready & reset is not accepted.

Decomposition:
- Shared package split_issue_pkg holds:
  - OFF_W = $clog2(LINE_BYTES)
  - LINE_W = ADDR_W - OFF_W
  - BANK_W = max(1, $clog2(NBANKS))
  - part encoding constants PART_LO = 0, PART_HI = 1
  - FSM state enum {IDLE, ISSUE}
- One combinational sub-module, line_rotate_mask, computes rotated data, low mask, high mask and crossing from (off, size, data). The top level holds the FSM, pend bits and per-bank output muxing.

Test Plan (LINE_BYTES=16, NBANKS=2, ADDR_W=15 unless noted):
1. Write, addr 0x0104, size 3, wdata bytes 0..3 = AA BB CC DD, banks ready → one cycle later bank0 valid, line 0x010, mask 0x00F0, bytes 4..7 = AA BB CC DD, split 0; IDLE one cycle after that.
2. addr 0x010E, size 3 → bank0: line 0x010, mask 0xC000, part 0. Bank1: line 0x011, mask 0x0003, part 1. Both split = 1 and valid in the same cycle.
3. Same as 2 with bank_ready[1] = 0 for 3 cycles → bank0 accepted in the first cycle and drops. Bank1 outputs stay stable. req_ready stays 0 until bank1 is accepted, and returns to 1 the next cycle.
4. addr 0x7FFC, size 7 → low: line 0x7FF (bank1), mask 0xF000. High: line 0x000 (bank0), mask 0x000F.
5. NBANKS = 1, addr 0x001F, size 1 → low part (line 0x001, mask 0x8000) in cycle 1. High part (line 0x002, mask 0x0001) in the cycle after low is accepted.
6. Assert reset during ISSUE with bank_ready = 0 → the next cycle all bank_valid = 0, busy = 0, req_ready = 1. A new request is then accepted normally.
